nn_result_reader: RTL

- Consumer of the accelerator's 32-bit output-neuron stream; the read side of the `values` result interface.
- Accepts one signed score per output class per inference and tracks the running maximum.
- Presents the predicted digit (argmax), its score, and a frame-length error flag to the host/monitor logic.
- Sits between `nn_accelerator_top` and the host readout path, on the same clock.

---
 rtl/nn_result_reader.sv | 99 +++++++++
 1 files changed

// File: rtl/nn_result_reader.sv
// Read side of the accelerator's output-neuron stream: argmax over one frame of
// signed class scores, held for the host until acknowledged.
module nn_result_reader #(
    parameter int DATA_W      = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              result_valid,
    input  logic              result_ack,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              len_err,
    output logic [CNT_W-1:0]  frame_count
);

    // state | meaning
    // COLLECT | accepting score beats, tracking running max
    // HOLD    | result registers valid, waiting for result_ack
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_CLASSES - 1);

    logic [0:0]        state;
    logic [IDX_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] max_score;
    logic [IDX_W-1:0]  max_idx;

    logic              beat_fire;
    logic              frame_end;
    logic              take_beat;
    logic [DATA_W-1:0] next_score;
    logic [IDX_W-1:0]  next_idx;

    // Ready is gated by rst so the upstream never sees a handshake during reset.
    assign in_ready  = (state == COLLECT) && !rst;
    assign beat_fire = in_valid && in_ready;
    assign frame_end = beat_fire && (in_last || (beat_cnt == LAST_BEAT));

    // Strictly greater keeps the lower index on ties; beat 0 always seeds the max.
    always_comb begin
        take_beat  = (beat_cnt == '0) || ($signed(in_data) > $signed(max_score));
        next_score = max_score;
        next_idx   = max_idx;
        if (take_beat) begin
            next_score = in_data;
            next_idx   = beat_cnt;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state        <= COLLECT;
            beat_cnt     <= '0;
            max_score    <= '0;
            max_idx      <= '0;
            result_valid <= 1'b0;
            class_idx    <= '0;
            class_score  <= '0;
            len_err      <= 1'b0;
            frame_count  <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (frame_end) begin
                        class_idx    <= next_idx;
                        class_score  <= next_score;
                        len_err      <= !(in_last && (beat_cnt == LAST_BEAT));
                        result_valid <= 1'b1;
                        if (frame_count != '1) begin
                            frame_count <= frame_count + CNT_W'(1);
                        end
                        beat_cnt     <= '0;
                        state        <= HOLD;
                    end else if (beat_fire) begin
                        max_score <= next_score;
                        max_idx   <= next_idx;
                        beat_cnt  <= beat_cnt + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        state        <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
